// File: rtl/i2c_packet_tx.sv
// Three-byte I2C write master (START, 3 x {8 data + ACK}, STOP) for WM8731-style codecs.
// SCL is push-pull; SDA is open-drain via i2c_sdat_oe. One bit period = 4 quarters of CLK_DIV clocks.
module i2c_packet_tx #(
  parameter int CLK_DIV = 125
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [23:0] packet,
  output logic        busy,
  output logic        done,
  output logic        ack_error,
  output logic        i2c_sclk,
  output logic        i2c_sdat_oe,
  input  logic        i2c_sdat_i
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam logic [15:0] LP_DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] LP_DIV_PRE  = (CLK_DIV > 1) ? 16'(CLK_DIV - 2) : 16'd0;

  logic [2:0]  r_state;
  logic [1:0]  r_q;
  logic [15:0] r_div;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte;
  logic [23:0] r_shift;
  logic        r_busy;
  logic        r_done;
  logic        r_ack_error;
  logic        r_sclk;
  logic        r_sdat_oe;
  logic        r_sda_meta;
  logic        r_sda_sync;

  logic        w_tick;
  logic        w_accept;
  logic        w_done_next;
  logic        w_sclk;
  logic        w_sdat_oe;

  assign w_tick   = r_busy && (r_div == LP_DIV_LAST);
  assign w_accept = start && !r_busy;

  // done is registered, so it is raised one cycle ahead of the final quarter tick
  always_comb begin
    w_done_next = 1'b0;
    if (CLK_DIV == 1) begin
      w_done_next = (r_state == ST_STOP) && (r_q == 2'd2) && w_tick;
    end else begin
      w_done_next = (r_state == ST_STOP) && (r_q == 2'd3) && (r_div == LP_DIV_PRE);
    end
  end

  always_comb begin
    w_sclk    = 1'b1;
    w_sdat_oe = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sclk    = 1'b1;
        w_sdat_oe = 1'b0;
      end
      ST_START: begin
        w_sclk    = (r_q != 2'd3);
        w_sdat_oe = r_q[1];
      end
      ST_DATA: begin
        w_sclk    = (r_q == 2'd1) || (r_q == 2'd2);
        w_sdat_oe = !r_shift[23];
      end
      ST_ACK: begin
        w_sclk    = (r_q == 2'd1) || (r_q == 2'd2);
        w_sdat_oe = 1'b0;
      end
      ST_STOP: begin
        w_sclk    = (r_q != 2'd0);
        w_sdat_oe = !r_q[1];
      end
      default: begin
        w_sclk    = 1'b1;
        w_sdat_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_div <= 16'd0;
    end else if (!r_busy || w_tick || w_accept) begin
      r_div <= 16'd0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // two-flop synchronizer on the open-drain SDA line
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
    end else begin
      r_sda_meta <= i2c_sdat_i;
      r_sda_sync <= r_sda_meta;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_q         <= 2'd0;
      r_bit       <= 3'd0;
      r_byte      <= 2'd0;
      r_shift     <= 24'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ack_error <= 1'b0;
      r_sclk      <= 1'b1;
      r_sdat_oe   <= 1'b0;
    end else begin
      r_done    <= w_done_next;
      r_sclk    <= w_sclk;
      r_sdat_oe <= w_sdat_oe;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_shift     <= packet;
          r_busy      <= 1'b1;
          r_state     <= ST_START;
          r_q         <= 2'd0;
          r_bit       <= 3'd0;
          r_byte      <= 2'd0;
          r_ack_error <= 1'b0;
        end
      end else if (w_tick) begin
        r_q <= r_q + 2'd1;
        if ((r_state == ST_ACK) && (r_q == 2'd2) && r_sda_sync) begin
          r_ack_error <= 1'b1;
        end
        if (r_q == 2'd3) begin
          case (r_state)
            ST_START: r_state <= ST_DATA;
            ST_DATA: begin
              r_shift <= {r_shift[22:0], 1'b0};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_state <= ST_ACK;
              end
            end
            ST_ACK: begin
              r_bit <= 3'd0;
              if (r_ack_error || (r_byte == 2'd2)) begin
                r_state <= ST_STOP;
              end else begin
                r_state <= ST_DATA;
                r_byte  <= r_byte + 2'd1;
              end
            end
            ST_STOP: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
            default: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign ack_error   = r_ack_error;
  assign i2c_sclk    = r_sclk;
  assign i2c_sdat_oe = r_sdat_oe;

endmodule

// File: tb/tb_i2c_packet_tx.sv
// Scoreboard bench for i2c_packet_tx: expected SDA frames are queued at start, a bus
// monitor with a simple ACK/NACK slave decodes frames between START and STOP and compares.
module tb_i2c_packet_tx;

  localparam int CLK_DIV = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] packet = 24'd0;
  logic        busy;
  logic        done;
  logic        ack_error;
  logic        i2c_sclk;
  logic        i2c_sdat_oe;
  logic        i2c_sdat_i;
  logic        slave_pull = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  bit          mon_en = 1'b0;
  bit          in_frame = 1'b0;
  bit          frame_nack = 1'b0;
  int          frame_len = 0;
  logic [31:0] frame_bits = 32'd0;

  int          exp_len_q[$];
  logic [31:0] exp_bits_q[$];
  bit          exp_nack_q[$];

  assign i2c_sdat_i = !(i2c_sdat_oe || slave_pull);

  always #5 Clk = ~Clk;

  i2c_packet_tx #(.CLK_DIV(CLK_DIV)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .start(start),
    .packet(packet),
    .busy(busy),
    .done(done),
    .ack_error(ack_error),
    .i2c_sclk(i2c_sclk),
    .i2c_sdat_oe(i2c_sdat_oe),
    .i2c_sdat_i(i2c_sdat_i)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin : done_counter
    forever begin
      @(posedge Clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
  end

  // bus monitor, protocol checker and slave ACK responder
  initial begin : monitor
    logic p_scl, p_sda, scl, sda;
    int   el;
    logic [31:0] eb;
    bit   nk;
    p_scl = 1'b1;
    p_sda = 1'b1;
    forever begin
      @(negedge Clk);
      scl = i2c_sclk;
      sda = i2c_sdat_i;
      if (mon_en) begin
        if (p_scl && scl && p_sda && !sda) begin
          check_val("start_from_idle", 32'(in_frame), 32'd0);
          in_frame   = 1'b1;
          frame_len  = 0;
          frame_bits = 32'd0;
          frame_nack = (exp_nack_q.size() > 0) ? exp_nack_q[0] : 1'b0;
        end else if (p_scl && scl && !p_sda && sda) begin
          check_val("stop_in_frame", 32'(in_frame), 32'd1);
          if (in_frame) begin
            if (exp_len_q.size() == 0) begin
              check_val("frame_expected", 32'd0, 32'd1);
            end else begin
              el = exp_len_q.pop_front();
              eb = exp_bits_q.pop_front();
              nk = exp_nack_q.pop_front();
              // the last captured rise belongs to STOP, not to the frame
              check_val("frame_len", 32'(frame_len - 1), 32'(el));
              check_val("frame_bits", frame_bits >> 1, eb);
            end
          end
          in_frame = 1'b0;
        end else if (!p_scl && scl && in_frame) begin
          frame_bits = {frame_bits[30:0], sda};
          frame_len++;
        end else if (p_scl && !scl && in_frame) begin
          if ((frame_len % 9) == 8) slave_pull = !frame_nack;
          else slave_pull = 1'b0;
        end
      end
      p_scl = scl;
      p_sda = !(i2c_sdat_oe || slave_pull);
    end
  end

  task automatic push_expect(input logic [23:0] pkt, input bit nack);
    exp_nack_q.push_back(nack);
    if (nack) begin
      exp_len_q.push_back(9);
      exp_bits_q.push_back({23'd0, pkt[23:16], 1'b1});
    end else begin
      exp_len_q.push_back(27);
      exp_bits_q.push_back({5'd0, pkt[23:16], 1'b0, pkt[15:8], 1'b0, pkt[7:0], 1'b0});
    end
  endtask

  // called at a falling edge; start is accepted on the next rising edge
  task automatic xfer(input logic [23:0] pkt, input bit nack, input bit repulse);
    int n;
    int d0;
    int exp_cyc;
    exp_cyc = 4 * CLK_DIV * (nack ? 11 : 29);
    push_expect(pkt, nack);
    d0     = done_cnt;
    start  = 1'b1;
    packet = pkt;
    @(posedge Clk);
    #1;
    start  = 1'b0;
    packet = ~pkt;
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("ack_err_cleared", 32'(ack_error), 32'd0);
    n = 1;
    while (done !== 1'b1 && n < 1000) begin
      if (repulse && n == 40) begin
        start  = 1'b1;
        packet = 24'hFFFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge Clk);
      #1;
      n++;
    end
    check_val("done_cycle", 32'(n), 32'(exp_cyc));
    check_val("busy_in_done", 32'(busy), 32'd1);
    start  = 1'b1;
    packet = 24'h5A5A5A;
    @(posedge Clk);
    #1;
    start = 1'b0;
    check_val("busy_fall", 32'(busy), 32'd0);
    check_val("done_width", 32'(done), 32'd0);
    check_val("ack_error", 32'(ack_error), 32'(nack));
    repeat (6) @(posedge Clk);
    #1;
    check_val("ack_error_hold", 32'(ack_error), 32'(nack));
    check_val("done_count", 32'(done_cnt - d0), 32'd1);
    check_val("idle_after_done", 32'(busy), 32'd0);
    check_val("frames_consumed", 32'(exp_len_q.size()), 32'd0);
    @(negedge Clk);
  endtask

  // reset lands mid-byte1; returns at a falling edge with Reset just released
  task automatic abort_xfer(input logic [23:0] pkt);
    push_expect(pkt, 1'b0);
    start  = 1'b1;
    packet = pkt;
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (96) @(posedge Clk);
    #1;
    check_val("busy_before_abort", 32'(busy), 32'd1);
    mon_en = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check_val("rst_sclk", 32'(i2c_sclk), 32'd1);
    check_val("rst_sda_oe", 32'(i2c_sdat_oe), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_ack_error", 32'(ack_error), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    exp_len_q.delete();
    exp_bits_q.delete();
    exp_nack_q.delete();
    in_frame   = 1'b0;
    slave_pull = 1'b0;
    Reset      = 1'b0;
    mon_en     = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "bench did not complete");
  end

  initial begin : stimulus
    logic [23:0] rpkt;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_ack_error", 32'(ack_error), 32'd0);
    check_val("reset_sclk", 32'(i2c_sclk), 32'd1);
    check_val("reset_sda_oe", 32'(i2c_sdat_oe), 32'd0);
    @(negedge Clk);
    Reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge Clk);

    xfer(24'h341E00, 1'b0, 1'b0);
    xfer(24'h341E00, 1'b1, 1'b0);
    xfer(24'h3412F0, 1'b0, 1'b0);
    xfer(24'h34A5C3, 1'b0, 1'b1);
    abort_xfer(24'h340C55);
    xfer(24'h340817, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rpkt = 24'($urandom);
      xfer(rpkt, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_packet_tx.md
I2C_PACKET_TX -- requirements
Module: i2c_packet_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other logic is synchronous to Clk.
REQ-002 The block SHALL have parameter CLK_DIV, default 125, meaning Clk cycles per I2C quarter-bit (legal range 1..65535; 50 MHz / (4*125) = 100 kHz SCL).
REQ-003 The block SHALL have port Clk, input, 1, system clock.
REQ-004 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to send packet.
REQ-006 The block SHALL have port packet, input, 24, byte2 = {dev_addr[6:0], R/W}, byte1 and byte0 = WM8731 register word, sent MSB first.
REQ-007 The block SHALL have port busy, output, 1, transfer in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse at end of transfer.
REQ-009 The block SHALL have port ack_error, output, 1, sticky NACK flag for the last transfer.
REQ-010 The block SHALL have port i2c_sclk, output, 1, SCL line (push-pull).
REQ-011 The block SHALL have port i2c_sdat_oe, output, 1, 1 = pull SDA low, 0 = release SDA.
REQ-012 The block SHALL have port i2c_sdat_i, input, 1, sampled SDA line.

Function
REQ-013 A quarter tick SHALL occur every CLK_DIV Clk cycles while busy; the divider SHALL be cleared when start is accepted.
REQ-014 Each bit period SHALL be 4 quarters: q0 SCL low with SDA driven; q1 SCL high; q2 SCL high with SDA sampled; q3 SCL low.
REQ-015 The FSM SHALL use the states IDLE, START, DATA, ACK, STOP, and its transitions SHALL be IDLE->START, START->DATA, DATA->ACK after 8 bits, ACK->DATA for the next byte, ACK->STOP after byte0 or on NACK, and STOP->IDLE.
REQ-016 In IDLE, the block SHALL drive i2c_sclk=1 and i2c_sdat_oe=0.
REQ-017 In IDLE, start=1 SHALL latch packet into a shift register, and busy SHALL be 1 from the next edge.
REQ-018 start SHALL be ignored while busy=1, and packet changes during a transfer SHALL have no effect.
REQ-019 START SHALL last one bit period: q0-q1 with SCL=1 and SDA released, q2 with SDA low and SCL=1, q3 with SCL low and SDA low.
REQ-020 DATA SHALL shift out 8 bits MSB first; SDA SHALL change only during q0, when SCL is low.
REQ-021 ACK SHALL release SDA for one bit period and sample i2c_sdat_i in q2; a sampled 1 SHALL be a NACK.
REQ-022 STOP SHALL last one bit period: q0 with SCL low and SDA low, q1 with SCL high, q2-q3 with SDA released and SCL high.
REQ-023 A full transfer SHALL be 29 bit periods (1 START + 27 DATA/ACK + 1 STOP) = 116*CLK_DIV Clk cycles from the first quarter of START.
REQ-024 At the end of STOP q3, done SHALL pulse for exactly 1 cycle and busy SHALL fall on the same edge.
REQ-025 On NACK, the block SHALL set ack_error=1, skip the remaining bytes, and execute STOP, with done still pulsing.
REQ-026 ack_error SHALL hold its value until the next accepted start clears it.
REQ-027 If start is asserted in the same cycle that done pulses, start SHALL be ignored, because busy is still 1 in that cycle.

Reset
REQ-028 Reset=1 SHALL immediately force i2c_sclk=1, i2c_sdat_oe=0, busy=0, done=0, ack_error=0, FSM=IDLE, and clear the divider and bit counters, including mid-transfer.
REQ-029 After Reset deasserts, the block SHALL accept start on the first rising Clk edge.

Verification
REQ-030 The bench SHALL cover this case: with CLK_DIV=2, start with packet=24'h341E00 and a slave ACKing all bytes -> SDA bits 0011_0100,A,0001_1110,A,0000_0000,A; done at 232 cycles; ack_error=0.
REQ-031 The bench SHALL cover this case: with CLK_DIV=2, a NACK on the first ACK -> ack_error=1, STOP follows directly, done after 11 bit periods (88 cycles).
REQ-032 The bench SHALL cover this case: start re-pulsed mid-transfer with a different packet -> the original bitstream is unchanged and only one done pulse occurs.
REQ-033 The bench SHALL cover this case: Reset asserted during byte1 -> SCL=1 and SDA released in the same cycle and busy=0, then a new start completes normally.
REQ-034 The bench SHALL cover this case: a protocol checker over all transfers -> SDA never toggles while SCL=1 except START (falling) and STOP (rising).
REQ-035 The bench SHALL cover this case: NACK on transfer 1 then ACK on transfer 2 -> ack_error is 1 after transfer 1, 0 from the second accepted start, and 0 at end.
